// File: rtl/fast_window_builder.sv
// 7x7 sliding-window builder for the FAST-16 front end: six line buffers plus a 7x7 register array.
// Optional FAST_WB_FRAME_CHECK_EN adds a sticky frame_err output for truncated frames and missing sof.
module fast_window_builder #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    localparam int XW = $clog2(IMG_WIDTH),
    localparam int YW = $clog2(IMG_HEIGHT)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 pix_valid,
    input  logic                                 pix_sof,
    input  logic [DATA_WIDTH-1:0]                pix_data,
    output logic                                 window_valid,
    output logic [0:6][0:6][DATA_WIDTH-1:0]      window,
    output logic [XW-1:0]                        center_x,
    output logic [YW-1:0]                        center_y,
`ifdef FAST_WB_FRAME_CHECK_EN
    output logic                                 frame_err,
`endif
    output logic                                 frame_done
);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [XW-1:0] X_MIN  = XW'(6);
    localparam logic [YW-1:0] Y_MIN  = YW'(6);

    logic [XW-1:0] col_cnt_reg, col_cnt_next;
    logic [YW-1:0] row_cnt_reg, row_cnt_next;
    logic [XW-1:0] x_cur;
    logic [YW-1:0] y_cur;
    logic          accept;
    logic          last_pix;
    logic          window_valid_reg;
    logic          frame_done_reg;
    logic [XW-1:0] center_x_reg;
    logic [YW-1:0] center_y_reg;

    // Column vector entering the window: row 0 is the live pixel, rows 1..6 come from LB0..LB5.
    logic [DATA_WIDTH-1:0] col_vec [0:6];

    // A reset cycle drops any pixel presented alongside it.
    assign accept   = pix_valid && !rst;
    assign last_pix = (x_cur == X_LAST) && (y_cur == Y_LAST);

    always_comb begin
        x_cur        = pix_sof ? '0 : col_cnt_reg;
        y_cur        = pix_sof ? '0 : row_cnt_reg;
        col_cnt_next = x_cur + XW'(1);
        row_cnt_next = y_cur;
        if (x_cur == X_LAST) begin
            col_cnt_next = '0;
            row_cnt_next = (y_cur == Y_LAST) ? '0 : y_cur + YW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt_reg      <= '0;
            row_cnt_reg      <= '0;
            window_valid_reg <= 1'b0;
            frame_done_reg   <= 1'b0;
            center_x_reg     <= '0;
            center_y_reg     <= '0;
        end else begin
            window_valid_reg <= pix_valid && (x_cur >= X_MIN) && (y_cur >= Y_MIN);
            frame_done_reg   <= pix_valid && last_pix;
            if (pix_valid) begin
                col_cnt_reg  <= col_cnt_next;
                row_cnt_reg  <= row_cnt_next;
                center_x_reg <= x_cur - XW'(3);
                center_y_reg <= y_cur - YW'(3);
            end
        end
    end

    assign col_vec[0] = pix_data;

    // Cascaded line buffers: each reads the old value at x and takes the value from the line above.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_lb
            logic [DATA_WIDTH-1:0] mem [0:IMG_WIDTH-1];

            always_ff @(posedge clk) begin
                if (accept) begin
                    mem[x_cur] <= col_vec[gi];
                end
            end

            assign col_vec[gi+1] = mem[x_cur];
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_row
            logic [0:6][DATA_WIDTH-1:0] row_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    row_reg <= '0;
                end else if (pix_valid) begin
                    row_reg <= {row_reg[1:6], col_vec[gi]};
                end
            end

            assign window[gi] = row_reg;
        end
    endgenerate

`ifdef FAST_WB_FRAME_CHECK_EN
    logic frame_err_reg;
    logic frame_ended_reg;
    logic at_origin;

    assign at_origin = (col_cnt_reg == '0) && (row_cnt_reg == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_reg   <= 1'b0;
            frame_ended_reg <= 1'b0;
        end else if (pix_valid) begin
            frame_ended_reg <= last_pix;
            if ((pix_sof && !at_origin) || (!pix_sof && at_origin && frame_ended_reg)) begin
                frame_err_reg <= 1'b1;
            end
        end
    end

    assign frame_err = frame_err_reg;
`endif

    assign window_valid = window_valid_reg;
    assign frame_done   = frame_done_reg;
    assign center_x     = center_x_reg;
    assign center_y     = center_y_reg;

endmodule

// File: tb/tb_fast_window_builder.sv
// Scoreboard bench for fast_window_builder on a 16x12 image; expected windows come from a 2-D image model.
module tb_fast_window_builder;

    localparam int W  = 16;
    localparam int H  = 12;
    localparam int DW = 8;
    localparam int WB = 7 * 7 * DW;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        pix_valid;
    logic                        pix_sof;
    logic [DW-1:0]               pix_data;
    logic                        window_valid;
    logic [0:6][0:6][DW-1:0]     window;
    logic [3:0]                  center_x;
    logic [3:0]                  center_y;
    logic                        frame_done;
`ifdef FAST_WB_FRAME_CHECK_EN
    logic                        frame_err;
`endif

    fast_window_builder #(
        .DATA_WIDTH(DW),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_valid   (pix_valid),
        .pix_sof     (pix_sof),
        .pix_data    (pix_data),
        .window_valid(window_valid),
        .window      (window),
        .center_x    (center_x),
        .center_y    (center_y),
`ifdef FAST_WB_FRAME_CHECK_EN
        .frame_err   (frame_err),
`endif
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                      cx;
        int                      cy;
        logic [0:6][0:6][DW-1:0] win;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] img [0:H-1][0:W-1];
    int            mx, my;
    bit            exp_err, model_ended;
    int            n_cmp, n_bad;
    int            n_win, n_done;
    int            first_idx, first_cx, first_cy;
    logic [0:6][0:6][DW-1:0] first_w;
    int            wrap_cx, wrap_w33;
    bit            got_valid;
    logic [0:6][0:6][DW-1:0] last_w;
    int            last_cx, last_cy;

    task automatic check_eq(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit v, input bit sof, input logic [DW-1:0] d);
        int   x, y;
        bit   exp_valid, exp_done;
        exp_t e;
        exp_t f;
        pix_valid = v;
        pix_sof   = sof;
        pix_data  = d;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        if (v) begin
            x = sof ? 0 : mx;
            y = sof ? 0 : my;
            if (sof && (mx != 0 || my != 0)) exp_err = 1'b1;
            if (!sof && mx == 0 && my == 0 && model_ended) exp_err = 1'b1;
            model_ended = (x == W-1) && (y == H-1);
            img[y][x] = d;
            if (x >= 6 && y >= 6) begin
                e.cx = x - 3;
                e.cy = y - 3;
                for (int r = 0; r < 7; r++)
                    for (int c = 0; c < 7; c++)
                        e.win[r][c] = img[y-r][x-6+c];
                sb_q.push_back(e);
                exp_valid = 1'b1;
            end
            exp_done = model_ended;
            if (x == W-1) begin
                mx = 0;
                my = (y == H-1) ? 0 : y + 1;
            end else begin
                mx = x + 1;
                my = y;
            end
        end
        @(posedge clk);
        #1;
        check_eq("window_valid", window_valid, exp_valid);
        check_eq("frame_done", frame_done, exp_done);
`ifdef FAST_WB_FRAME_CHECK_EN
        check_eq("frame_err", frame_err, exp_err);
`endif
        if (frame_done) n_done++;
        got_valid = window_valid;
        if (window_valid) begin
            check_eq("sb_nonempty", (sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                f = sb_q.pop_front();
                check_eq("center_x", center_x, f.cx);
                check_eq("center_y", center_y, f.cy);
                check_eq("window", window, f.win);
                $display("window cx=%0d cy=%0d w33=%0d", center_x, center_y, window[3][3]);
            end
            n_win++;
            last_w  = window;
            last_cx = center_x;
            last_cy = center_y;
        end else if (exp_valid && sb_q.size() > 0) begin
            void'(sb_q.pop_front());
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic reset_pulse();
        rst       = 1'b1;
        pix_valid = 1'b1;
        pix_sof   = 1'b0;
        pix_data  = 8'hA5;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        pix_valid = 1'b0;
        check_eq("rst_valid", window_valid, 0);
        check_eq("rst_done", frame_done, 0);
        check_eq("rst_cx", center_x, 0);
        check_eq("rst_cy", center_y, 0);
        check_eq("rst_window", window, 0);
`ifdef FAST_WB_FRAME_CHECK_EN
        check_eq("rst_err", frame_err, 0);
`endif
        mx = 0; my = 0;
        exp_err = 1'b0;
        model_ended = 1'b0;
        sb_q.delete();
        $display("reset applied");
    endtask

    // off < 0 streams an all-0xFF frame; otherwise pixel = x + 16*y + off.
    task automatic send_frame(input int off, input bit gaps, input bit with_sof, input int n_pix);
        int x, y;
        logic [DW-1:0] d;
        n_win = 0; n_done = 0; first_idx = -1; wrap_cx = -1; wrap_w33 = -1;
        for (int i = 0; i < n_pix; i++) begin
            x = i % W;
            y = i / W;
            d = (off < 0) ? 8'hFF : DW'(x + 16*y + off);
            if (gaps) begin
                int g;
                g = $urandom_range(0, 3);
                for (int k = 0; k < g; k++) step(1'b0, 1'b0, 8'h00);
            end
            step(1'b1, with_sof && (i == 0), d);
            if (got_valid && first_idx < 0) begin
                first_idx = i; first_w = last_w; first_cx = last_cx; first_cy = last_cy;
            end
            if (got_valid && last_cy == 5 && wrap_cx < 0) begin
                wrap_cx = last_cx; wrap_w33 = int'(last_w[3][3]);
            end
        end
    endtask

    task automatic check_ramp_frame(input string tag);
        check_eq({tag, "_first_idx"}, first_idx, 102);
        check_eq({tag, "_first_cx"}, first_cx, 3);
        check_eq({tag, "_first_cy"}, first_cy, 3);
        check_eq({tag, "_w33"}, first_w[3][3], 51);
        check_eq({tag, "_w06"}, first_w[0][6], 102);
        check_eq({tag, "_w60"}, first_w[6][0], 0);
        check_eq({tag, "_wrap_cx"}, wrap_cx, 3);
        check_eq({tag, "_wrap_w33"}, wrap_w33, 83);
        check_eq({tag, "_n_win"}, n_win, 60);
        check_eq({tag, "_n_done"}, n_done, 1);
    endtask

    initial begin
        logic [0:6][0:6][DW-1:0] all_ff;
        n_cmp = 0; n_bad = 0;
        mx = 0; my = 0; exp_err = 1'b0; model_ended = 1'b0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = '0;
        pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_pulse();

        // Continuous ramp, including line-wrap behaviour
        send_frame(0, 1'b0, 1'b1, W*H);
        check_ramp_frame("t1");

        // Same ramp with random idle gaps
        send_frame(0, 1'b1, 1'b1, W*H);
        check_ramp_frame("t2");

        // Frame truncated by sof at (4,8), then a full +100 frame
        send_frame(0, 1'b0, 1'b1, 4 + 8*W);
        check_eq("t4_abort_done", n_done, 0);
        send_frame(100, 1'b0, 1'b1, W*H);
        check_eq("t4_n_win", n_win, 60);
        check_eq("t4_w33", first_w[3][3], 151);
        check_eq("t4_n_done", n_done, 1);
`ifdef FAST_WB_FRAME_CHECK_EN
        check_eq("t4_err_sticky", frame_err, 1);
`endif

        // Reset mid-frame after (9,9), then restream
        send_frame(0, 1'b0, 1'b1, 10 + 9*W);
        reset_pulse();
        send_frame(0, 1'b0, 1'b1, W*H);
        check_ramp_frame("t5");

        // Back-to-back frames, second all 0xFF
        send_frame(0, 1'b0, 1'b1, W*H);
        check_eq("t6a_n_win", n_win, 60);
        send_frame(-1, 1'b0, 1'b1, W*H);
        all_ff = '1;
        check_eq("t6_first_idx", first_idx, 102);
        check_eq("t6_first_cy", first_cy, 3);
        check_eq("t6_all_ff", first_w, all_ff);
        check_eq("t6_n_win", n_win, 60);

        // Frame without sof after a completed frame
        send_frame(0, 1'b0, 1'b0, W*H);
        check_eq("t7_n_win", n_win, 60);
        check_eq("t7_n_done", n_done, 1);

        repeat (3) step(1'b0, 1'b0, 8'h00);
        check_eq("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fast_window_builder.md
Name: fast_window_builder

Overview:
- Builds the 7x7 pixel neighbourhood consumed by the FAST-16 circle sampler from a raster-order grayscale pixel stream.
- Holds six full-width line buffers plus a 7x7 shift-register array.
- Emits one registered window per accepted pixel whose window lies fully inside the image, together with the centre coordinates.
- Sits between the camera/ISP pixel stream and the FAST detector front end.

Parameters:
- DATA_WIDTH, 8: pixel bit width.
- IMG_WIDTH, 640: pixels per line; minimum 7.
- IMG_HEIGHT, 480: lines per frame; minimum 7.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- pix_valid  input  1  pixel present this cycle. No backpressure: every pix_valid cycle is accepted.
- pix_sof  input  1  qualified by pix_valid; marks the pixel at (x=0, y=0) of a new frame.
- pix_data  input  DATA_WIDTH  pixel value.
- window_valid  output  1  window[] and coordinates are valid this cycle.
- window  output  DATA_WIDTH x [0:6][0:6]  window[row][col]. Row 0 is the newest line and row 6 the oldest. Col 6 is the newest pixel and col 0 the oldest. Centre is window[3][3].
- center_x  output  $clog2(IMG_WIDTH)  x coordinate of window[3][3].
- center_y  output  $clog2(IMG_HEIGHT)  y coordinate of window[3][3].
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset:
  - window_valid, frame_done, center_x and center_y go to 0.
  - All window[] registers clear to 0.
  - col_cnt = 0, row_cnt = 0.
  - Line-buffer contents are not reset. Outputs never depend on stale line data because window_valid is gated by the counters.
- Accept rule: a pixel is accepted on every cycle with pix_valid=1. Gaps (pix_valid=0) hold all state, and window_valid=0 during them.
- Counters:
  - The accepted pixel is at (col_cnt, row_cnt). If pix_sof=1, it is forced to (0,0) regardless of the counters.
  - After acceptance, col_cnt increments. At IMG_WIDTH-1 it wraps to 0 and row_cnt increments.
  - At (IMG_WIDTH-1, IMG_HEIGHT-1) both counters wrap to 0.
- Line buffers:
  - LB0..LB5 are addressed by the accepted pixel's x.
  - Same-cycle read-before-write: LB0 writes pix_data, and LBk writes the old read value of LB(k-1).
  - Column vector for this cycle: {pix_data, LB0_rd, ..., LB5_rd}, giving rows 0..6 at column x.
- Window shift:
  - On acceptance, every row shifts left (col c takes col c+1), and col 6 loads the column vector.
- Output timing (latency 1 cycle from the accepting edge):
  - window_valid is registered to 1 iff the accepted pixel has x >= 6 and y >= 6.
  - center_x = x-3 and center_y = y-3.
  - This suppresses windows that straddle a line wrap or the top edge.
- Window count: exactly (IMG_WIDTH-6)*(IMG_HEIGHT-6) windows per complete frame.
- frame_done is registered to 1 on the cycle after the pixel at (IMG_WIDTH-1, IMG_HEIGHT-1) is accepted; 0 otherwise.
- Mid-frame pix_sof:
  - The frame restarts immediately.
  - No window is emitted until the new frame reaches y >= 6.
  - No frame_done is issued for the aborted frame.
- First frame after reset without pix_sof: treated as starting at (0,0).
- Reset mid-frame: takes priority over pix_valid in the same cycle; the pixel is dropped.

Optional Feature:
- Macro: FAST_WB_FRAME_CHECK_EN.
- When defined, adds output frame_err (1 bit, reset 0, sticky until rst). It is set on the cycle after either:
  - a pix_sof arrives while (col_cnt,row_cnt) != (0,0), i.e. a truncated frame; or
  - a pixel with pix_sof=0 is accepted at counter (0,0) after a frame_done, i.e. a missing sof.
- In both cases counting still follows the normal rules.
- When not defined: no frame_err port and no checking logic.

Test Plan:
All tests use IMG_WIDTH=16, IMG_HEIGHT=12, DATA_WIDTH=8, and a ramp frame with pixel = x + 16*y.
1. Continuous ramp frame, sof on first pixel:
   - The first window_valid occurs 1 cycle after the 103rd pixel (x=6, y=6).
   - window[3][3]=51, window[0][6]=102, window[6][0]=0, center=(3,3).
   - Exactly 60 valid windows; frame_done pulses once, 1 cycle after pixel 191.
2. Same ramp with random 0-3 cycle gaps in pix_valid: identical window sequence and values to test 1, and window_valid=0 during gaps.
3. At the line wrap (pixel (15,7) then (0,8)): no window_valid for x=0..5 of line 8. The next window has center=(3,5) and window[3][3]=83.
4. pix_sof injected at pixel (4,8) of frame 1, then a full frame 2 with values +100:
   - No frame_done for frame 1.
   - Frame 2 emits 60 windows; the first has window[3][3]=151.
   - With FAST_WB_FRAME_CHECK_EN, frame_err=1 one cycle after that sof.
5. rst asserted for 1 cycle mid-frame (after pixel (9,9)):
   - All outputs are 0 the next cycle.
   - Restreaming frame from sof gives results identical to test 1.
6. Two back-to-back frames with no idle cycle (second frame all pixels 0xFF):
   - No window of frame 2 is valid before y=6.
   - All 49 entries of its first window are 0xFF.
